fifo_burst_writer: RTL and testbench
====================================

# fifo_burst_writer

Producer-side burst engine that sits directly upstream of `async_fifo` in the write (PROD_CLK) domain. On a start pulse it writes a programmed number of words into the FIFO, inserting a programmable idle gap between writes. Each word comes from a selectable pattern source: zero, ones, LFSR-random or incrementing. It stalls on FULL without dropping or duplicating words, and flags completion with a one-cycle DONE pulse.

## Interface
- P_DATA_WIDTH, 8: FIFO word width; legal range 1..16.
- P_MAX_BURST, 1024: maximum words per burst.
- P_IDLE_W, 4: width of the idle-gap field.
- PROD_CLK  in  1  write-domain clock; all logic on rising edge.
- RST_n  in  1  reset, synchronous and active-low.
- START  in  1  single-cycle burst request; honoured only in IDLE.
- BURST_LEN  in  $clog2(P_MAX_BURST+1)  words to write; values above P_MAX_BURST are clamped.
- IDLE_CYC  in  P_IDLE_W  idle cycles between consecutive accepted writes.
- MODE  in  2  pattern select: 00 zero, 11 all-ones, 01 LFSR random, 10 incrementing.
- SEED  in  16  LFSR seed; 0 is replaced by 16'hACE1.
- I_FULL  in  1  FIFO full flag (write domain).
- O_WR_EN  out  1  FIFO write enable.
- O_DATA  out  P_DATA_WIDTH  FIFO write data.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse at burst completion.
- WR_COUNT  out  $clog2(P_MAX_BURST+1)  accepted writes in the current or last burst.

## Operation
- States: IDLE, WRITE, GAP, FIN.
- IDLE
  - On START, latch len = min(BURST_LEN, P_MAX_BURST), plus IDLE_CYC, MODE and SEED.
  - Clear WR_COUNT and load the pattern generator.
  - If len == 0, go to FIN; otherwise go to WRITE.
- WRITE
  - O_WR_EN = !I_FULL. This path is combinational, so the write is never issued while FULL.
  - Accepted write (O_WR_EN=1 at the edge): WR_COUNT++ and the pattern generator advances.
  - If WR_COUNT+1 == len, go to FIN.
  - Else if IDLE_CYC > 0, go to GAP with gap counter = IDLE_CYC.
  - Else stay in WRITE.
  - While I_FULL=1: stay in WRITE with O_DATA held and no count change.
- GAP
  - O_WR_EN=0; decrement the gap counter each cycle.
  - When it reaches 1, go to WRITE.
  - I_FULL is ignored here.
- FIN: DONE=1 for exactly one cycle, then go to IDLE.
- START outside IDLE is ignored. Latched parameters are frozen for the whole burst.
- Pattern rules:
  - Zero: 0.
  - Ones: all bits 1.
  - Incrementing: starts at 0, +1 per accepted write, wraps mod 2^P_DATA_WIDTH.
  - LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400, shift right.
    - O_DATA = lfsr[P_DATA_WIDTH-1:0].
    - The first word is the seed value itself; the LFSR steps once per accepted write.
- WR_COUNT holds its final value after FIN until the next accepted START.

## Timing
- Reset: with RST_n low at an edge, the block enters IDLE and these outputs are 0 from the next cycle: O_WR_EN, O_DATA, BUSY, DONE, WR_COUNT.
- Reset mid-burst aborts immediately: no DONE, and the remaining words are discarded.
- START sampled at edge N puts the block in WRITE during cycle N+1. The first O_WR_EN can occur in cycle N+1.
- BUSY rises in cycle N+1 and falls the cycle after DONE.
- Gap spacing: accepted writes are spaced exactly IDLE_CYC+1 cycles apart when unstalled.
- Unstalled burst length: L words occupy L + (L-1)·IDLE_CYC cycles. DONE is in the cycle immediately after the last write.
- FULL stall: the gap counter does not run during a stall. The gap starts only after an accepted write.
- FULL deasserting mid-cycle in WRITE enables the write in that same cycle.
- len == 0: DONE in cycle N+1 with no writes.

## Test plan
- Reset: hold RST_n=0 for 3 cycles during an active burst -> all outputs 0 the following cycle; no DONE; next START is accepted normally.
- Incrementing mode: MODE=10, BURST_LEN=5, IDLE_CYC=0, FULL=0 -> O_WR_EN high for 5 consecutive cycles, data 0,1,2,3,4, DONE 1 cycle later, WR_COUNT=5.
- Gap and ones:
  - Stimulus: MODE=11, BURST_LEN=3, IDLE_CYC=2.
  - Response: writes at cycles N+1, N+4, N+7, all with data 8'hFF.
  - DONE at N+8.
- FULL back-pressure:
  - Stimulus: MODE=10, len=4; FULL held high for 6 cycles after the second write.
  - Response: no write while FULL; the third write carries data 2 (no skip, no duplicate); total of 4 writes.
- LFSR and clamp:
  - Stimulus: MODE=01, SEED=0, BURST_LEN=P_MAX_BURST+7, run against a reference LFSR in the scoreboard.
  - Response: first word is 8'hE1, the exact sequence matches the reference, and WR_COUNT=1024.
- Edge requests:
  - BURST_LEN=0 -> DONE at N+1 with no O_WR_EN.
  - START pulsed mid-burst -> ignored; burst count unchanged.

Source files
------------

// File: rtl/fifo_burst_writer.sv
// Producer-side burst engine: writes a programmed number of pattern words into
// an async FIFO with a programmable inter-write gap, stalling on FULL.
module fifo_burst_writer #(
   parameter int unsigned P_DATA_WIDTH = 8,
   parameter int unsigned P_MAX_BURST  = 1024,
   parameter int unsigned P_IDLE_W     = 4
) (
   input  logic                                 PROD_CLK,
   input  logic                                 RST_n,
   input  logic                                 START,
   input  logic [$clog2(P_MAX_BURST+1)-1:0]     BURST_LEN,
   input  logic [P_IDLE_W-1:0]                  IDLE_CYC,
   input  logic [1:0]                           MODE,
   input  logic [15:0]                          SEED,
   input  logic                                 I_FULL,
   output logic                                 O_WR_EN,
   output logic [P_DATA_WIDTH-1:0]              O_DATA,
   output logic                                 BUSY,
   output logic                                 DONE,
   output logic [$clog2(P_MAX_BURST+1)-1:0]     WR_COUNT
);

   localparam int unsigned LW        = $clog2(P_MAX_BURST + 1);
   localparam logic [15:0] SEED_ZERO = 16'hACE1;
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   localparam logic [1:0] MODE_ZERO = 2'b00;
   localparam logic [1:0] MODE_LFSR = 2'b01;
   localparam logic [1:0] MODE_INC  = 2'b10;
   localparam logic [1:0] MODE_ONES = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_GAP   = 2'd2,
      S_FIN   = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [LW-1:0]           len_q, len_d;
   logic [LW-1:0]           cnt_q, cnt_d;
   logic [P_IDLE_W-1:0]     idle_q, idle_d;
   logic [P_IDLE_W-1:0]     gap_q, gap_d;
   logic [1:0]              mode_q, mode_d;
   logic [15:0]             lfsr_q, lfsr_d;
   logic [P_DATA_WIDTH-1:0] data_q, data_d;

   logic [15:0]             seed_eff;
   logic [15:0]             lfsr_nxt;
   logic [LW-1:0]           len_clamp;
   logic [LW-1:0]           cnt_inc;
   logic                    wr_en;

   // Write enable follows FULL combinationally so a write is never issued into a full FIFO
   assign wr_en     = (state_q == S_WRITE) && !I_FULL;
   assign seed_eff  = (SEED == 16'h0000) ? SEED_ZERO : SEED;
   assign lfsr_nxt  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
   assign len_clamp = (BURST_LEN > LW'(P_MAX_BURST)) ? LW'(P_MAX_BURST) : BURST_LEN;
   assign cnt_inc   = cnt_q + LW'(1);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      gap_d   = gap_q;
      mode_d  = mode_q;
      lfsr_d  = lfsr_q;
      data_d  = data_q;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               len_d  = len_clamp;
               idle_d = IDLE_CYC;
               mode_d = MODE;
               lfsr_d = seed_eff;
               cnt_d  = '0;
               gap_d  = '0;
               case (MODE)
                  MODE_ONES: data_d = {P_DATA_WIDTH{1'b1}};
                  MODE_LFSR: data_d = seed_eff[P_DATA_WIDTH-1:0];
                  MODE_INC:  data_d = '0;
                  default:   data_d = '0;
               endcase
               state_d = (len_clamp == '0) ? S_FIN : S_WRITE;
            end
         end

         S_WRITE: begin
            if (wr_en) begin
               cnt_d  = cnt_inc;
               lfsr_d = lfsr_nxt;
               case (mode_q)
                  MODE_ONES: data_d = {P_DATA_WIDTH{1'b1}};
                  MODE_LFSR: data_d = lfsr_nxt[P_DATA_WIDTH-1:0];
                  MODE_INC:  data_d = data_q + P_DATA_WIDTH'(1);
                  MODE_ZERO: data_d = '0;
                  default:   data_d = '0;
               endcase
               if (cnt_inc == len_q) begin
                  state_d = S_FIN;
               end else if (idle_q != '0) begin
                  gap_d   = idle_q;
                  state_d = S_GAP;
               end
            end
         end

         // Gap counter runs only after an accepted write; FULL is irrelevant here
         S_GAP: begin
            gap_d = gap_q - P_IDLE_W'(1);
            if (gap_q <= P_IDLE_W'(1)) begin
               state_d = S_WRITE;
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge PROD_CLK) begin
      if (!RST_n) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         idle_q  <= '0;
         gap_q   <= '0;
         mode_q  <= MODE_ZERO;
         lfsr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         gap_q   <= gap_d;
         mode_q  <= mode_d;
         lfsr_q  <= lfsr_d;
         data_q  <= data_d;
      end
   end

   assign O_WR_EN  = wr_en;
   assign O_DATA   = data_q;
   assign BUSY     = (state_q != S_IDLE);
   assign DONE     = (state_q == S_FIN);
   assign WR_COUNT = cnt_q;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Randomized bench for fifo_burst_writer; expected write stream and timing come
// from a word queue plus a cycles-since-last-write spacing rule.
module tb_fifo_burst_writer;

   localparam int unsigned W   = 8;
   localparam int unsigned MAX = 1024;
   localparam int unsigned LW  = $clog2(MAX + 1);
   localparam int unsigned IW  = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [LW-1:0] burst_len;
   logic [IW-1:0] idle_cyc;
   logic [1:0]    mode;
   logic [15:0]   seed;
   logic          full;
   logic          wr_en;
   logic [W-1:0]  data;
   logic          busy;
   logic          done;
   logic [LW-1:0] wr_count;

   int n_checks = 0;
   int n_errors = 0;

   fifo_burst_writer #(
      .P_DATA_WIDTH (W),
      .P_MAX_BURST  (MAX),
      .P_IDLE_W     (IW)
   ) dut (
      .PROD_CLK  (clk),
      .RST_n     (rst_n),
      .START     (start),
      .BURST_LEN (burst_len),
      .IDLE_CYC  (idle_cyc),
      .MODE      (mode),
      .SEED      (seed),
      .I_FULL    (full),
      .O_WR_EN   (wr_en),
      .O_DATA    (data),
      .BUSY      (busy),
      .DONE      (done),
      .WR_COUNT  (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // full_pol: 0 never full, 1 random full, 2 full for 6 cycles after the 2nd write
   task automatic run_burst(input int len, input int idle, input int md,
                            input logic [15:0] sd, input int full_pol, input bit poke);
      logic [W-1:0] q[$];
      logic [15:0]  lf;
      int           nexp;
      int           nwr;
      int           since;
      int           hold;
      int           cyc;
      bit           exp_wr;
      bit           f;

      nexp = (len > MAX) ? MAX : len;
      lf   = (sd == 16'h0) ? 16'hACE1 : sd;
      for (int k = 0; k < nexp; k++) begin
         case (md)
            1:       q.push_back(lf[W-1:0]);
            2:       q.push_back(W'(k % (1 << W)));
            3:       q.push_back({W{1'b1}});
            default: q.push_back('0);
         endcase
         lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
      end

      @(negedge clk);
      burst_len = LW'(len);
      idle_cyc  = IW'(idle);
      mode      = 2'(md);
      seed      = sd;
      full      = 1'b0;
      start     = 1'b1;

      nwr = 0; since = 0; hold = 0; cyc = 0;
      while (q.size() > 0 && cyc < 4000) begin
         @(negedge clk);
         start     = (poke && cyc == 3);
         burst_len = LW'($urandom_range(0, MAX + 7));
         idle_cyc  = IW'($urandom);
         mode      = 2'($urandom);
         seed      = 16'($urandom);
         if (hold > 0) begin
            f = 1'b1;
            hold--;
         end else if (full_pol == 1) begin
            f = ($urandom_range(0, 2) == 0);
         end else begin
            f = 1'b0;
         end
         full = f;
         #1;
         exp_wr = !f && (nwr == 0 || since >= idle);
         check("wr_en", 32'(wr_en), 32'(exp_wr));
         check("busy", 32'(busy), 32'd1);
         check("done_early", 32'(done), 32'd0);
         check("wr_count", 32'(wr_count), 32'(nwr));
         if (exp_wr) begin
            check("data", 32'(data), 32'(q[0]));
            void'(q.pop_front());
            nwr++;
            since = 0;
            if (full_pol == 2 && nwr == 2) hold = 6;
         end else begin
            since++;
         end
         cyc++;
      end
      check("burst_timeout", 32'(q.size()), 32'd0);

      @(negedge clk);
      start = 1'b0;
      full  = 1'($urandom);
      #1;
      check("done", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd1);
      check("done_wr_en", 32'(wr_en), 32'd0);
      check("final_count", 32'(wr_count), 32'(nexp));

      @(negedge clk);
      #1;
      check("done_pulse", 32'(done), 32'd0);
      check("busy_fall", 32'(busy), 32'd0);
      check("count_hold", 32'(wr_count), 32'(nexp));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      check({tag, "_data"}, 32'(data), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_count"}, 32'(wr_count), 32'd0);
   endtask

   task automatic reset_mid_burst();
      @(negedge clk);
      burst_len = LW'(20);
      idle_cyc  = IW'(1);
      mode      = 2'b10;
      seed      = 16'h0;
      full      = 1'b0;
      start     = 1'b1;
      repeat (6) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check_all_zero("rst_mid");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) begin
         @(negedge clk);
         full = 1'($urandom);
         #1;
         check("post_rst_done", 32'(done), 32'd0);
         check("post_rst_wr_en", 32'(wr_en), 32'd0);
      end
      full = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      burst_len = '0;
      idle_cyc  = '0;
      mode      = 2'b00;
      seed      = 16'h0;
      full      = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;

      run_burst(5, 0, 2, 16'h0, 0, 1'b0);
      run_burst(3, 2, 3, 16'h1234, 0, 1'b0);
      run_burst(4, 0, 2, 16'h0, 2, 1'b0);
      run_burst(MAX + 7, 0, 1, 16'h0, 0, 1'b0);
      run_burst(0, 3, 2, 16'h0, 0, 1'b0);
      run_burst(12, 1, 2, 16'h0, 0, 1'b1);
      run_burst(6, 15, 0, 16'h0, 1, 1'b0);
      reset_mid_burst();
      run_burst(7, 1, 2, 16'h0, 1, 1'b0);

      for (int i = 0; i < 12; i++) begin
         run_burst($urandom_range(0, 40), $urandom_range(0, 15), $urandom_range(0, 3),
                   16'($urandom), 1, 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
